// File: rtl/periph_reg_arbiter.sv
// periph_reg_arbiter: shares one register bus among NumReq requesters and NumSlv slaves.
// It handles one transaction at a time. Requesters are served round-robin. The slave is
// chosen by decoding 4 KiB windows above BaseAddr. A stalled slave is ended by a timeout.
//
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   req_valid_i/addr_i/write_i/wdata_i/    per-requester request, packed as requester i
//   req_wstrb_i                            at slice [W*i +: W]
//   rsp_ready_o/rsp_rdata_o/rsp_error_o    one-cycle completion pulse, plus read data and error
//   slv_valid_o                            one-hot request to the selected slave
//   slv_addr_o/write_o/wdata_o/wstrb_o     registered request fields, broadcast to all slaves
//   slv_ready_i/slv_rdata_i/slv_error_i    per-slave response
module periph_reg_arbiter #(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned NumSlv        = 4,
   parameter logic [63:0] BaseAddr      = 64'h1000_0000,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NumReq-1:0]    req_valid_i,
   input  logic [NumReq*64-1:0] req_addr_i,
   input  logic [NumReq-1:0]    req_write_i,
   input  logic [NumReq*32-1:0] req_wdata_i,
   input  logic [NumReq*4-1:0]  req_wstrb_i,
   output logic [NumReq-1:0]    rsp_ready_o,
   output logic [31:0]          rsp_rdata_o,
   output logic                 rsp_error_o,
   output logic [NumSlv-1:0]    slv_valid_o,
   output logic [63:0]          slv_addr_o,
   output logic                 slv_write_o,
   output logic [31:0]          slv_wdata_o,
   output logic [3:0]           slv_wstrb_o,
   input  logic [NumSlv-1:0]    slv_ready_i,
   input  logic [NumSlv*32-1:0] slv_rdata_i,
   input  logic [NumSlv-1:0]    slv_error_i
);

   localparam int unsigned ReqIdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned SlvIdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1;
   localparam int unsigned CntW    = 16;
   localparam logic [31:0]     TimeoutRdata = 32'hBADC_AB1E;
   // The timeout fires in the BUSY cycle in which the count would reach TimeoutCycles.
   // So the access spends exactly TimeoutCycles cycles in BUSY.
   localparam logic [CntW-1:0] CntLast      = CntW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e               state_q, state_d;
   logic [ReqIdxW-1:0]   rr_q, rr_d, win_q, win_d;
   logic [SlvIdxW-1:0]   sel_q, sel_d;
   logic [63:0]          addr_q, addr_d;
   logic                 write_q, write_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           wstrb_q, wstrb_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [NumSlv-1:0]    slv_valid_q, slv_valid_d;
   logic [NumReq-1:0]    rsp_ready_q, rsp_ready_d;
   logic [31:0]          rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_error_q, rsp_error_d;

   logic [63:0]          addr_arr  [NumReq];
   logic [31:0]          wdata_arr [NumReq];
   logic [3:0]           wstrb_arr [NumReq];
   logic [31:0]          rdata_arr [NumSlv];

   logic                 arb_any, arb_mapped;
   logic [ReqIdxW-1:0]   arb_idx, cand;
   logic [63:0]          arb_addr, arb_off;
   logic [SlvIdxW-1:0]   arb_sel;
   logic                 busy_ready, busy_timeout;

   // Unpack the flat request and response vectors into per-index arrays.
   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         addr_arr[i]  = req_addr_i[i*64 +: 64];
         wdata_arr[i] = req_wdata_i[i*32 +: 32];
         wstrb_arr[i] = req_wstrb_i[i*4 +: 4];
      end
      for (int s = 0; s < NumSlv; s++) begin
         rdata_arr[s] = slv_rdata_i[s*32 +: 32];
      end
   end

   // Round-robin pick. Scanning downward means the candidate closest to rr_q is assigned last, so it wins.
   always_comb begin
      arb_any = 1'b0;
      arb_idx = '0;
      cand    = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         cand = ReqIdxW'((int'(rr_q) + k) % int'(NumReq));
         if (req_valid_i[cand]) begin
            arb_any = 1'b1;
            arb_idx = cand;
         end
      end
   end

   // Decode the winner's address. Comparing the offset avoids overflow at the top of the map.
   always_comb begin
      arb_addr   = addr_arr[arb_idx];
      arb_off    = arb_addr - BaseAddr;
      arb_mapped = (arb_addr >= BaseAddr) && (arb_off < (64'(NumSlv) << 12));
      arb_sel    = SlvIdxW'(arb_off >> 12);
   end

   assign busy_ready   = slv_ready_i[sel_q];
   assign busy_timeout = (cnt_q == CntLast);

   // State register plus all latched fields and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         rr_q        <= '0;
         win_q       <= '0;
         sel_q       <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         cnt_q       <= '0;
         slv_valid_q <= '0;
         rsp_ready_q <= '0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         win_q       <= win_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         cnt_q       <= cnt_d;
         slv_valid_q <= slv_valid_d;
         rsp_ready_q <= rsp_ready_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (arb_any) state_d = arb_mapped ? StBusy : StResp;
         StBusy:  if (busy_ready || busy_timeout) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Next values for the latched fields and the registered outputs.
   always_comb begin
      rr_d        = rr_q;
      win_d       = win_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      cnt_d       = cnt_q;
      slv_valid_d = '0;
      rsp_ready_d = '0;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (arb_any) begin
               win_d   = arb_idx;
               sel_d   = arb_sel;
               addr_d  = arb_addr;
               write_d = req_write_i[arb_idx];
               wdata_d = wdata_arr[arb_idx];
               wstrb_d = wstrb_arr[arb_idx];
               cnt_d   = '0;
               if (arb_mapped) begin
                  slv_valid_d[arb_sel] = 1'b1;
               end else begin
                  rsp_ready_d[arb_idx] = 1'b1;
                  rsp_error_d          = 1'b1;
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q + CntW'(1);
            if (busy_ready) begin
               rsp_ready_d[win_q] = 1'b1;
               rsp_error_d        = slv_error_i[sel_q];
               rsp_rdata_d        = write_q ? 32'h0 : rdata_arr[sel_q];
            end else if (busy_timeout) begin
               rsp_ready_d[win_q] = 1'b1;
               rsp_error_d        = 1'b1;
               rsp_rdata_d        = TimeoutRdata;
            end else begin
               slv_valid_d[sel_q] = 1'b1;
            end
         end
         StResp: begin
            rr_d = (win_q == ReqIdxW'(NumReq - 1)) ? '0 : win_q + ReqIdxW'(1);
         end
         default: ;
      endcase
   end

   assign rsp_ready_o = rsp_ready_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_error_o = rsp_error_q;
   assign slv_valid_o = slv_valid_q;
   assign slv_addr_o  = addr_q;
   assign slv_write_o = write_q;
   assign slv_wdata_o = wdata_q;
   assign slv_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_periph_reg_arbiter.sv
// Scoreboard bench for periph_reg_arbiter (2 requesters, 4 slaves, timeout of 4 cycles).
module tb_periph_reg_arbiter;

   typedef struct packed {
      logic [1:0]  rdy;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic         clk = 1'b0;
   logic         rst_ni;
   logic [1:0]   req_valid;
   logic [127:0] req_addr;
   logic [1:0]   req_write;
   logic [63:0]  req_wdata;
   logic [7:0]   req_wstrb;
   logic [1:0]   rsp_ready;
   logic [31:0]  rsp_rdata;
   logic         rsp_error;
   logic [3:0]   slv_valid;
   logic [63:0]  slv_addr;
   logic         slv_write;
   logic [31:0]  slv_wdata;
   logic [3:0]   slv_wstrb;
   logic [3:0]   slv_ready;
   logic [127:0] slv_rdata;
   logic [3:0]   slv_error;

   rsp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Slave 3 (UART) returns 0x55; slave 1 (boot ROM) returns 0x1234; slave 2 always reports an error.
   assign slv_rdata = {32'h0000_0055, 32'hAAAA_0002, 32'h0000_1234, 32'h1111_0000};
   assign slv_error = 4'b0100;

   periph_reg_arbiter #(
      .NumReq(2), .NumSlv(4), .BaseAddr(64'h1000_0000), .TimeoutCycles(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid), .req_addr_i(req_addr), .req_write_i(req_write),
      .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .rsp_ready_o(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
      .slv_valid_o(slv_valid), .slv_addr_o(slv_addr), .slv_write_o(slv_write),
      .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
      .slv_ready_i(slv_ready), .slv_rdata_i(slv_rdata), .slv_error_i(slv_error)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic rsp_t mk(input int idx, input logic [31:0] rd, input logic er);
      rsp_t r;
      r.rdy      = '0;
      r.rdy[idx] = 1'b1;
      r.rdata    = rd;
      r.err      = er;
      return r;
   endfunction

   // Monitor: every completion pulse is popped and compared against the scoreboard.
   always @(negedge clk) begin
      if (rst_ni && rsp_ready != 2'b00) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got rdy=%b rdata=%h err=%b with nothing expected",
                     rsp_ready, rsp_rdata, rsp_error);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            if ({rsp_ready, rsp_rdata, rsp_error} !== e) begin
               errors++;
               $display("FAIL rsp: got rdy=%b rdata=%h err=%b expected rdy=%b rdata=%h err=%b",
                        rsp_ready, rsp_rdata, rsp_error, e.rdy, e.rdata, e.err);
            end
         end
      end
   end

   // One request from a single requester. Checks the slave-side view at N+1 and the completion latency.
   task automatic do_single(input int idx, input logic [63:0] addr, input logic wr,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input logic [3:0] exp_sv, input int exp_lat, input rsp_t e);
      int lat;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid[idx]           = 1'b1;
      req_addr[idx*64 +: 64]   = addr;
      req_write[idx]           = wr;
      req_wdata[idx*32 +: 32]  = wd;
      req_wstrb[idx*4 +: 4]    = ws;
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
      @(negedge clk);
      chk("slv_valid_n1", 128'(slv_valid), 128'(exp_sv));
      chk("slv_fields_n1", 128'({slv_addr, slv_write, slv_wdata, slv_wstrb}),
          128'({addr, wr, wd, ws}));
      lat = 1;
      while (rsp_ready == 2'b00 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 128'(lat), 128'(exp_lat));
   endtask

   // Both requesters are valid together with a zero-wait slave.
   // Requester 0 is granted at P1 and requester 1 at P4; each drops valid just after its grant.
   task automatic do_pair(input logic [63:0] addr, input logic wr, input rsp_t e0, input rsp_t e1);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      @(posedge clk); #1;
      req_valid = 2'b11;
      req_addr  = {addr, addr};
      req_write = {wr, wr};
      req_wdata = {32'hDEAD_0001, 32'hDEAD_0000};
      req_wstrb = 8'hFF;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_ni    = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_write = '0;
      req_wdata = '0;
      req_wstrb = '0;
      slv_ready = 4'hF;
      #12;
      chk("rst_rsp_ready", 128'(rsp_ready), 128'(0));
      chk("rst_rsp_rdata", 128'(rsp_rdata), 128'(0));
      chk("rst_rsp_error", 128'(rsp_error), 128'(0));
      chk("rst_slv_valid", 128'(slv_valid), 128'(0));
      chk("rst_slv_fields", 128'({slv_addr, slv_write, slv_wdata, slv_wstrb}), 128'(0));
      @(negedge clk);
      rst_ni = 1'b1;

      // Simultaneous writes from reset: requester 0 first, then 1. A second pair shows rr is back at 0.
      do_pair(64'h1000_0000, 1'b1, mk(0, 32'h0, 1'b0), mk(1, 32'h0, 1'b0));
      do_pair(64'h1000_1000, 1'b0, mk(0, 32'h1234, 1'b0), mk(1, 32'h1234, 1'b0));

      // UART read.
      do_single(0, 64'h1000_3004, 1'b0, 32'h0, 4'h0, 4'b1000, 2, mk(0, 32'h55, 1'b0));
      // Unmapped addresses: far away, just below the base, and one past the last window.
      do_single(1, 64'h2000_0000, 1'b0, 32'h0, 4'h0, 4'b0000, 1, mk(1, 32'h0, 1'b1));
      do_single(0, 64'h0FFF_FFFC, 1'b0, 32'h0, 4'h0, 4'b0000, 1, mk(0, 32'h0, 1'b1));
      do_single(0, 64'h1000_4000, 1'b0, 32'h0, 4'h0, 4'b0000, 1, mk(0, 32'h0, 1'b1));
      // Last word of the last window.
      do_single(1, 64'h1000_3FFC, 1'b0, 32'h0, 4'h0, 4'b1000, 2, mk(1, 32'h55, 1'b0));
      // Writes return zero read data; slave 2 reports an error.
      do_single(1, 64'h1000_2010, 1'b1, 32'hCAFE_F00D, 4'b0110, 4'b0100, 2, mk(1, 32'h0, 1'b1));
      do_single(0, 64'h1000_0008, 1'b1, 32'h0000_0001, 4'b1111, 4'b0001, 2, mk(0, 32'h0, 1'b0));

      // Boot ROM never ready: 4 BUSY cycles, then the timeout response.
      slv_ready = 4'b1101;
      do_single(0, 64'h1000_1000, 1'b0, 32'h0, 4'h0, 4'b0010, 5, mk(0, 32'hBADC_AB1E, 1'b1));
      chk("timeout_valid_dropped", 128'(slv_valid), 128'(0));

      // Ready arrives in the timeout cycle (sampled at P5), so the slave response wins.
      fork
         do_single(0, 64'h1000_1000, 1'b0, 32'h0, 4'h0, 4'b0010, 5, mk(0, 32'h1234, 1'b0));
         begin
            repeat (5) @(posedge clk);
            #1;
            slv_ready = 4'hF;
         end
      join

      // Reset during BUSY: requester 0 goes first so rr_q becomes 1, then requester 1 stalls.
      do_single(0, 64'h1000_3004, 1'b0, 32'h0, 4'h0, 4'b1000, 2, mk(0, 32'h55, 1'b0));
      slv_ready = 4'b1101;
      @(posedge clk); #1;
      req_valid[1]       = 1'b1;
      req_addr[127:64]   = 64'h1000_1000;
      req_write[1]       = 1'b0;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("busy_before_reset", 128'(slv_valid), 128'(4'b0010));
      #2;
      rst_ni = 1'b0;
      #1;
      chk("reset_async_outputs", 128'({slv_valid, rsp_ready}), 128'(0));
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      repeat (6) @(negedge clk);
      slv_ready = 4'hF;
      do_pair(64'h1000_3000, 1'b0, mk(0, 32'h55, 1'b0), mk(1, 32'h55, 1'b0));

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
